fsab_arbiter: RTL and testbench
===============================

# fsab_arbiter

Four-client arbiter for the FSAB outbound request bus. It sits between up to four bus masters (CPU instruction cache, data cache, framebuffer, DMA) and a single FSAB target (memory controller or simulation memory). It shares the one credit-managed `fsabo_*` channel using round-robin arbitration and locks onto a client for the full duration of a write burst. It owns the downstream credit pool. The return channel `fsabi_*` is broadcast to all clients unmodified, and each client filters it by DID outside this block.

## Interface
Parameters:
- None. Widths come from `fsab_defines.vh`: `FSAB_REQ_HI`, `FSAB_DID_HI`, `FSAB_ADDR_HI`, `FSAB_LEN_HI`, `FSAB_DATA_HI`, `FSAB_MASK_HI`, `FSAB_CREDITS_HI`, `FSAB_INITIAL_CREDITS`, `FSAB_WRITE`.
- Client count is fixed at 4. Client k occupies slice `[k*W +: W]` of each flattened bus.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `Nrst`  in  1  asynchronous, active-low reset.
- `cli_valid`  in  4  client k presents a beat; held until acked.
- `cli_mode`  in  4*(FSAB_REQ_HI+1)  per-client request mode.
- `cli_did`, `cli_subdid`  in  4*(FSAB_DID_HI+1) each  per-client IDs.
- `cli_addr`  in  4*(FSAB_ADDR_HI+1)  per-client address.
- `cli_len`  in  4*(FSAB_LEN_HI+1)  per-client burst length.
- `cli_data`  in  4*(FSAB_DATA_HI+1)  per-client write data.
- `cli_mask`  in  4*(FSAB_MASK_HI+1)  per-client byte mask.
- `cli_ack`  out  4  one-hot; beat from client k accepted this cycle.
- `fsabo_valid`, `fsabo_mode`, `fsabo_did`, `fsabo_subdid`, `fsabo_addr`, `fsabo_len`, `fsabo_data`, `fsabo_mask`  out  FSAB widths  registered outbound bus.
- `fsabo_credit`  in  1  target returns one request credit.

## Operation
- Credit counter `cred`, width FSAB_CREDITS_HI+2:
  - Range 0..FSAB_INITIAL_CREDITS.
  - Decrements by 1 on each accepted header beat.
  - Increments by 1 on each `fsabo_credit` pulse.
  - Simultaneous decrement and increment leaves it unchanged.
  - A credit returned while `cred`==FSAB_INITIAL_CREDITS raises `$error` and the counter saturates.
- Request shape:
  - A read (mode != FSAB_WRITE) is 1 beat.
  - A write is `len` beats; the header fields are sampled on the first beat only.
  - A write with `len`==0 is illegal: it raises `$error` and is treated as 1 beat.
- FSM state IDLE:
  - Candidates are clients with `cli_valid` set.
  - Priority starts at `rr_last+1` mod 4.
  - If `cred`>0 and a candidate exists, grant the first candidate:
    - assert its `cli_ack` in the same cycle (combinational);
    - load the output registers;
    - set `rr_last` to that client;
    - decrement `cred`.
  - Grant of a write with `len`>1 moves to BURST with `rem`=`len`-1. Otherwise stay in IDLE.
  - If `cred`==0, no ack is issued.
- FSM state BURST:
  - Owner is locked; no other client is acked.
  - Each cycle the owner has `cli_valid`:
    - ack it;
    - forward data/mask, with header fields reissued from the owner's current inputs;
    - decrement `rem`.
  - If the owner drops `cli_valid`, `fsabo_valid` is 0 that cycle (a bubble) and `rem` holds.
  - Data beats do not consume credits.
  - When `rem` reaches 0 on an accepted beat, return to IDLE.
- Non-granted clients see `cli_ack`=0 and must hold their inputs.

## Timing
- Reset values (async, on `Nrst` low):
  - `fsabo_valid`=0; all other `fsabo_*` outputs = 0.
  - `cli_ack`=0.
  - `cred`=FSAB_INITIAL_CREDITS.
  - `rr_last`=3, so client 0 wins first.
  - FSM=IDLE, `rem`=0.
- Reset mid-burst abandons the burst. The target is reset with the same `Nrst`.
- Latency: a beat acked in cycle N appears on `fsabo_*` with `fsabo_valid`=1 in cycle N+1. Minimum client-to-bus latency is 1 cycle.
- Throughput:
  - One beat per cycle.
  - Back-to-back single-beat requests from different clients are legal in consecutive cycles while `cred`>0.
  - The cycle after the last beat of a burst can carry a new header.
- A credit returned in cycle N is usable for a grant decision in cycle N+1, not in cycle N.
- `fsabo_valid`=0 in every cycle following a cycle with no ack.

## Test plan
- **Reset / single read:** Client 2 read, `len`=1. Expected: `cli_ack`=4'b0100 in cycle 0; `fsabo_valid`=1 with client 2's addr/did in cycle 1; `cred` = INITIAL-1.
- **Round-robin:** All four clients hold single-beat reads continuously with ample credits. Expected: ack order 0,1,2,3,0,…, one grant per cycle, no skipped client.
- **Write burst lock:** Client 1 write `len`=4 while client 0 is also valid. Expected: four consecutive acks to client 1, client 0 acked on the 5th cycle, one credit consumed by the burst.
- **Burst bubble:** Client 3 write `len`=3 drops `cli_valid` for 2 cycles after beat 1. Expected: `fsabo_valid` low for exactly 2 cycles, no other client acked, remaining 2 beats forwarded.
- **Credit exhaustion:** Issue INITIAL reads with no returns, then 1 more. Expected: the extra request is not acked until one cycle after a `fsabo_credit` pulse; `cred` never goes below 0.
- **Simultaneous spend/return:** Pulse `fsabo_credit` in the same cycle as a header ack with `cred`=1. Expected: `cred` remains 1.

Source files
------------

// File: rtl/fsab_arbiter.sv
// Four-client round-robin arbiter for the FSAB outbound request bus.
// It owns the downstream credit pool and locks onto a client for a whole write burst.
`timescale 1ns/1ps

package fsab_pkg;
  // Mirrors the widths normally provided by fsab_defines.vh.
  localparam int FSAB_REQ_HI          = 0;
  localparam int FSAB_DID_HI          = 3;
  localparam int FSAB_ADDR_HI         = 30;
  localparam int FSAB_LEN_HI          = 2;
  localparam int FSAB_DATA_HI         = 63;
  localparam int FSAB_MASK_HI         = 7;
  localparam int FSAB_CREDITS_HI      = 2;
  localparam int FSAB_INITIAL_CREDITS = 4;
  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;
endpackage

module fsab_arbiter
  import fsab_pkg::*;
(
  input  logic                          clk,
  input  logic                          Nrst,
  input  logic [3:0]                    cli_valid,
  input  logic [4*(FSAB_REQ_HI+1)-1:0]  cli_mode,
  input  logic [4*(FSAB_DID_HI+1)-1:0]  cli_did,
  input  logic [4*(FSAB_DID_HI+1)-1:0]  cli_subdid,
  input  logic [4*(FSAB_ADDR_HI+1)-1:0] cli_addr,
  input  logic [4*(FSAB_LEN_HI+1)-1:0]  cli_len,
  input  logic [4*(FSAB_DATA_HI+1)-1:0] cli_data,
  input  logic [4*(FSAB_MASK_HI+1)-1:0] cli_mask,
  output logic [3:0]                    cli_ack,
  output logic                          fsabo_valid,
  output logic [FSAB_REQ_HI:0]          fsabo_mode,
  output logic [FSAB_DID_HI:0]          fsabo_did,
  output logic [FSAB_DID_HI:0]          fsabo_subdid,
  output logic [FSAB_ADDR_HI:0]         fsabo_addr,
  output logic [FSAB_LEN_HI:0]          fsabo_len,
  output logic [FSAB_DATA_HI:0]         fsabo_data,
  output logic [FSAB_MASK_HI:0]         fsabo_mask,
  input  logic                          fsabo_credit
);
  localparam int RW = FSAB_REQ_HI + 1;
  localparam int DW = FSAB_DID_HI + 1;
  localparam int AW = FSAB_ADDR_HI + 1;
  localparam int LW = FSAB_LEN_HI + 1;
  localparam int XW = FSAB_DATA_HI + 1;
  localparam int MW = FSAB_MASK_HI + 1;
  localparam int CW = FSAB_CREDITS_HI + 2;
  localparam logic [CW-1:0] CRED_INIT = CW'(FSAB_INITIAL_CREDITS);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        state;
  logic [CW-1:0] cred;
  logic [1:0]    rr_last;
  logic [1:0]    owner;
  logic [LW-1:0] rem;

  logic          grant;
  logic          header;
  logic [1:0]    sel;
  logic [1:0]    cand;

  logic [RW-1:0] sel_mode;
  logic [LW-1:0] sel_len;
  logic          sel_write;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    grant  = 1'b0;
    header = 1'b0;
    sel    = owner;
    cand   = rr_last;
    if (state == S_BURST) begin
      grant = cli_valid[owner];
    end else if (cred != '0) begin
      // Scan from farthest to nearest so the client right after rr_last wins.
      for (int i = 4; i >= 1; i--) begin
        cand = rr_last + 2'(i);
        if (cli_valid[cand]) begin
          grant = 1'b1;
          sel   = cand;
        end
      end
      header = grant;
    end
  end

  always_comb begin
    cli_ack = '0;
    if (grant) cli_ack[sel] = 1'b1;
  end

  assign sel_mode  = cli_mode[sel*RW +: RW];
  assign sel_len   = cli_len[sel*LW +: LW];
  assign sel_write = (sel_mode == FSAB_WRITE);

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state        <= S_IDLE;
      cred         <= CRED_INIT;
      rr_last      <= 2'd3;
      owner        <= 2'd0;
      rem          <= '0;
      fsabo_valid  <= 1'b0;
      fsabo_mode   <= '0;
      fsabo_did    <= '0;
      fsabo_subdid <= '0;
      fsabo_addr   <= '0;
      fsabo_len    <= '0;
      fsabo_data   <= '0;
      fsabo_mask   <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      fsabo_valid <= grant;
      if (grant) begin
        fsabo_mode   <= sel_mode;
        fsabo_did    <= cli_did[sel*DW +: DW];
        fsabo_subdid <= cli_subdid[sel*DW +: DW];
        fsabo_addr   <= cli_addr[sel*AW +: AW];
        fsabo_len    <= sel_len;
        fsabo_data   <= cli_data[sel*XW +: XW];
        fsabo_mask   <= cli_mask[sel*MW +: MW];
      end

      assert (!(fsabo_credit && cred == CRED_INIT))
        else $error("fsab_arbiter: credit returned with pool already full");
      assert (!(header && sel_write && sel_len == '0))
        else $error("fsab_arbiter: write with len 0 from client %0d", sel);

      // A spend and a return in the same cycle cancel out.
      if (fsabo_credit && !header) begin
        if (cred != CRED_INIT) cred <= cred + CW'(1);
      end else if (header && !fsabo_credit) begin
        cred <= cred - CW'(1);
      end

      case (state)
        S_IDLE: begin
          if (header) begin
            rr_last <= sel;
            if (sel_write && sel_len > LW'(1)) begin
              state <= S_BURST;
              owner <= sel;
              rem   <= sel_len - LW'(1);
            end
          end
        end
        S_BURST: begin
          if (grant) begin
            rem <= rem - LW'(1);
            if (rem == LW'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsab_arbiter.sv
// Randomized scoreboard bench for fsab_arbiter: a request-level client/credit model predicts
// acks and outbound beats; a separate monitor compares what the DUT presents.
`timescale 1ns/1ps

module tb_fsab_arbiter;
  import fsab_pkg::*;

  localparam int RW   = FSAB_REQ_HI + 1;
  localparam int DW   = FSAB_DID_HI + 1;
  localparam int AW   = FSAB_ADDR_HI + 1;
  localparam int LW   = FSAB_LEN_HI + 1;
  localparam int XW   = FSAB_DATA_HI + 1;
  localparam int MW   = FSAB_MASK_HI + 1;
  localparam int INIT = FSAB_INITIAL_CREDITS;

  logic                clk = 1'b0;
  logic                Nrst = 1'b0;
  logic [3:0]          cli_valid = '0;
  logic [4*RW-1:0]     cli_mode = '0;
  logic [4*DW-1:0]     cli_did = '0;
  logic [4*DW-1:0]     cli_subdid = '0;
  logic [4*AW-1:0]     cli_addr = '0;
  logic [4*LW-1:0]     cli_len = '0;
  logic [4*XW-1:0]     cli_data = '0;
  logic [4*MW-1:0]     cli_mask = '0;
  logic [3:0]          cli_ack;
  logic                fsabo_valid;
  logic [RW-1:0]       fsabo_mode;
  logic [DW-1:0]       fsabo_did;
  logic [DW-1:0]       fsabo_subdid;
  logic [AW-1:0]       fsabo_addr;
  logic [LW-1:0]       fsabo_len;
  logic [XW-1:0]       fsabo_data;
  logic [MW-1:0]       fsabo_mask;
  logic                fsabo_credit = 1'b0;

  fsab_arbiter dut (
    .clk(clk), .Nrst(Nrst),
    .cli_valid(cli_valid), .cli_mode(cli_mode), .cli_did(cli_did), .cli_subdid(cli_subdid),
    .cli_addr(cli_addr), .cli_len(cli_len), .cli_data(cli_data), .cli_mask(cli_mask),
    .cli_ack(cli_ack),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0]       mode;
    logic [DW-1:0]       did;
    logic [DW-1:0]       subdid;
    logic [AW-1:0]       addr;
    logic [LW-1:0]       len;
    logic [7:0][XW-1:0]  data;
    logic [7:0][MW-1:0]  mask;
  } req_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [RW-1:0] mode;
    logic [DW-1:0] did;
    logic [DW-1:0] subdid;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [XW-1:0] data;
    logic [MW-1:0] mask;
  } beat_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  req_t       req_q[4][$];
  logic [3:0] ack_q[$];
  beat_t      beat_q[$];

  bit cur_valid[4];
  int beat_idx[4];
  int gap[4];
  int m_cred = INIT;
  int m_rr = 3;
  int credit_pct = 0;
  int start_pct = 100;
  int bubble_pct = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int beats_of(input req_t r);
    if (r.mode != FSAB_WRITE) return 1;
    return (r.len == '0) ? 1 : int'(r.len);
  endfunction

  function automatic bit pending();
    for (int k = 0; k < 4; k++) if (req_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_req(input int k, input bit wr, input int len);
    req_t r;
    r.mode   = wr ? FSAB_WRITE : ~FSAB_WRITE;
    r.did    = DW'($urandom);
    r.subdid = DW'($urandom);
    r.addr   = AW'($urandom);
    r.len    = wr ? LW'(len) : LW'($urandom_range(1, 7));
    for (int b = 0; b < 8; b++) begin
      r.data[b] = XW'({$urandom, $urandom});
      r.mask[b] = MW'($urandom);
    end
    req_q[k].push_back(r);
  endtask

  task automatic drive_client(input int k);
    req_t r;
    cli_valid[k] = cur_valid[k];
    if (cur_valid[k]) begin
      r = req_q[k][0];
      cli_mode[k*RW +: RW]   = r.mode;
      cli_did[k*DW +: DW]    = r.did;
      cli_subdid[k*DW +: DW] = r.subdid;
      cli_addr[k*AW +: AW]   = r.addr;
      cli_len[k*LW +: LW]    = r.len;
      cli_data[k*XW +: XW]   = r.data[beat_idx[k]];
      cli_mask[k*MW +: MW]   = r.mask[beat_idx[k]];
    end else begin
      cli_mode[k*RW +: RW]   = RW'($urandom);
      cli_did[k*DW +: DW]    = DW'($urandom);
      cli_subdid[k*DW +: DW] = DW'($urandom);
      cli_addr[k*AW +: AW]   = AW'($urandom);
      cli_len[k*LW +: LW]    = LW'($urandom);
      cli_data[k*XW +: XW]   = XW'({$urandom, $urandom});
      cli_mask[k*MW +: MW]   = MW'($urandom);
    end
  endtask

  // One bus cycle: called #1 after a rising edge, returns #1 after the next one.
  task automatic step();
    int    g;
    int    owner;
    bit    cr;
    req_t  r;
    beat_t b;
    cr = (m_cred < INIT) && ($urandom_range(99) < credit_pct);
    fsabo_credit = cr;
    for (int k = 0; k < 4; k++) begin
      if (!cur_valid[k] && req_q[k].size() > 0) begin
        if (beat_idx[k] > 0 && gap[k] > 0) gap[k]--;
        else cur_valid[k] = $urandom_range(99) < ((beat_idx[k] == 0) ? start_pct : 100 - bubble_pct);
      end
      drive_client(k);
    end

    // A client part-way through a write owns the bus; otherwise round-robin among ready clients.
    owner = -1;
    for (int k = 0; k < 4; k++) if (beat_idx[k] > 0) owner = k;
    g = -1;
    if (owner >= 0) begin
      if (cur_valid[owner]) g = owner;
    end else if (m_cred > 0) begin
      for (int i = 1; i <= 4 && g < 0; i++) if (cur_valid[(m_rr + i) % 4]) g = (m_rr + i) % 4;
    end

    ack_q.push_back((g >= 0) ? 4'(1 << g) : 4'b0000);
    if (g >= 0) begin
      r        = req_q[g][0];
      b.cyc    = 32'(cyc + 1);
      b.mode   = r.mode;
      b.did    = r.did;
      b.subdid = r.subdid;
      b.addr   = r.addr;
      b.len    = r.len;
      b.data   = r.data[beat_idx[g]];
      b.mask   = r.mask[beat_idx[g]];
      beat_q.push_back(b);
    end

    @(posedge clk);
    if (g >= 0) begin
      if (owner < 0) begin
        m_cred--;
        m_rr = g;
      end
      beat_idx[g]++;
      if (beat_idx[g] == beats_of(r)) begin
        void'(req_q[g].pop_front());
        beat_idx[g] = 0;
      end
      cur_valid[g] = 1'b0;
    end
    if (cr) m_cred++;
    #1;
    check("cred", dut.cred, m_cred);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    credit_pct = 100;
    while ((pending() || m_cred < INIT) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_done", {pending(), m_cred == INIT}, 2'b01);
  endtask

  // Monitor: compares the combinational ack and the registered outbound beat each cycle.
  always @(negedge clk) begin
    if (Nrst) begin
      if (ack_q.size() > 0) check("cli_ack", cli_ack, ack_q.pop_front());
      if (beat_q.size() > 0 && beat_q[0].cyc == 32'(cyc)) begin
        beat_t e;
        e = beat_q.pop_front();
        check("fsabo_valid", fsabo_valid, 1'b1);
        if (fsabo_valid) begin
          check("fsabo_hdr", {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len},
                {e.mode, e.did, e.subdid, e.addr, e.len});
          check("fsabo_data", {fsabo_data, fsabo_mask}, {e.data, e.mask});
        end
      end else begin
        check("fsabo_valid_idle", fsabo_valid, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      cur_valid[k] = 1'b0;
      beat_idx[k]  = 0;
      gap[k]       = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", cli_ack, 4'b0000);
    check("reset_valid", fsabo_valid, 1'b0);
    check("reset_bus", {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask}, '0);
    check("reset_cred", dut.cred, INIT);
    @(posedge clk);
    #1;
    Nrst = 1'b1;

    // Single read from client 2.
    add_req(2, 1'b0, 1);
    credit_pct = 0;
    run(3);
    check("single_read_cred", dut.cred, INIT - 1);
    drain(40);

    // Round-robin with all four clients continuously requesting.
    for (int n = 0; n < 6; n++) for (int k = 0; k < 4; k++) add_req(k, 1'b0, 1);
    drain(200);

    // Burst lock: client 0 is served first to place the pointer, then client 1 write vs client 0.
    add_req(0, 1'b0, 1);
    drain(40);
    add_req(1, 1'b1, 4);
    add_req(0, 1'b0, 1);
    drain(60);

    // Burst bubble: client 3 drops valid for two cycles after its first beat.
    gap[3] = 2;
    add_req(3, 1'b1, 3);
    add_req(0, 1'b0, 1);
    add_req(0, 1'b0, 1);
    drain(60);

    // Credit exhaustion: INIT+1 reads with no returns, then returns resume.
    for (int n = 0; n <= INIT; n++) add_req(n % 4, 1'b0, 1);
    credit_pct = 0;
    run(10);
    check("exhausted_cred", dut.cred, 0);
    drain(60);

    // Randomized mix of reads, writes, bubbles and credit returns.
    credit_pct = 40;
    start_pct  = 60;
    bubble_pct = 30;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 40) begin
        int k;
        k = $urandom_range(3);
        if (req_q[k].size() < 3) add_req(k, 1'($urandom_range(1)), $urandom_range(1, 7));
      end
      step();
    end
    drain(400);
    run(3);
    check("scoreboard_empty", {32'(beat_q.size()), 32'(ack_q.size())}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
